// File: rtl/led_bank_arbiter.sv
// ============================================================================
// led_bank_arbiter
//
// Shares the five board LEDs between NREQ status requesters. A requester
// raises req and presents its pattern on pat; the arbiter grants the bank to
// one requester at a time in round-robin order. Each grant is held for at
// least MIN_HOLD ticks. A grant is revoked after MAX_HOLD ticks if someone
// else is waiting. While nobody owns the bank, a walking-one heartbeat runs
// across the LEDs, advancing once per tick.
//
// Ports:
//   clki        system clock, rising edge
//   reset       asynchronous reset, active low
//   req[N]      per-requester request level, held until done
//   pat[5N]     per-requester LED pattern, requester i at [5i+4:5i]
//   gnt[N]      one-hot grant, registered
//   busy        high while any grant is active
//   led1..led5  registered LED drives (led1 = pattern bit 0)
// ============================================================================
module led_bank_arbiter #(
    parameter int NREQ     = 2,
    parameter int TICK_DIV = 1200000,
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clki,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    pat,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 led1,
    output logic                 led2,
    output logic                 led3,
    output logic                 led4,
    output logic                 led5
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] MIN_H     = HW'(MIN_HOLD);
    localparam logic [HW-1:0] MAX_H     = HW'(MAX_HOLD);
    localparam logic [LW-1:0] LAST_RST  = LW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e          state_q;
    logic [TW-1:0]   tcnt_q;
    logic [2:0]      hb_pos_q;
    logic [HW-1:0]   hold_q;
    logic [LW-1:0]   last_q;
    logic [NREQ-1:0] gnt_q;
    logic [4:0]      leds_q;

    logic            tick;
    logic [2:0]      hb_pos_d;
    logic [HW-1:0]   hold_d;
    logic [LW-1:0]   winner;
    logic            any_req;
    logic            cur_req;
    logic            other_req;
    logic            release_grant;
    logic [4:0]      cur_pat;
    logic [4:0]      win_pat;

    // Walking-one LED image for a heartbeat position.
    function automatic logic [4:0] hbLeds(input logic [2:0] pos);
        hbLeds = 5'b00001 << pos;
    endfunction

    // Prescaler tick, next heartbeat position and saturating hold increment.
    always_comb begin
        tick     = (tcnt_q == TCNT_LAST);
        hb_pos_d = (hb_pos_q == 3'd4) ? 3'd0 : hb_pos_q + 3'd1;
        hold_d   = (hold_q == MAX_H) ? hold_q : hold_q + HW'(1);
    end

    // Round-robin scan starting just after the last winner. While a grant
    // is active, last_q doubles as the index of the current owner.
    always_comb begin
        int  idx;
        logic found;
        winner = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = LW'(idx);
            end
        end
    end

    // Release on a finished owner past its minimum hold, or on preemption
    // once the maximum hold is reached and someone else is waiting.
    always_comb begin
        any_req       = |req;
        cur_req       = req[last_q];
        other_req     = |(req & ~gnt_q);
        cur_pat       = pat[5*int'(last_q) +: 5];
        win_pat       = pat[5*int'(winner) +: 5];
        release_grant = (!cur_req && (hold_q >= MIN_H)) ||
                        ((hold_q >= MAX_H) && other_req);
    end

    // Single sequencer: prescaler, heartbeat, arbitration and registered
    // outputs all update together so gnt and the LEDs switch on one edge.
    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            hb_pos_q <= 3'd0;
            hold_q   <= '0;
            last_q   <= LAST_RST;
            gnt_q    <= '0;
            leds_q   <= 5'b00001;
        end else begin
            tcnt_q <= tick ? '0 : tcnt_q + TW'(1);
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= GRANT;
                        gnt_q   <= NREQ'(1) << winner;
                        last_q  <= winner;
                        hold_q  <= '0;
                        leds_q  <= win_pat;
                    end else if (tick) begin
                        hb_pos_q <= hb_pos_d;
                        leds_q   <= hbLeds(hb_pos_d);
                    end else begin
                        leds_q <= hbLeds(hb_pos_q);
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        leds_q  <= hbLeds(hb_pos_q);
                    end else begin
                        leds_q <= cur_pat;
                        if (tick) begin
                            hold_q <= hold_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = |gnt_q;
    assign led1 = leds_q[0];
    assign led2 = leds_q[1];
    assign led3 = leds_q[2];
    assign led4 = leds_q[3];
    assign led5 = leds_q[4];

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter with a small tick period so
// every hold and heartbeat boundary is reached in a few dozen cycles.
module tb_led_bank_arbiter;

   localparam int NREQ = 2;
   localparam int TDIV = 4;
   localparam int MINH = 2;
   localparam int MAXH = 4;

   logic       clki  = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] req   = 2'b00;
   logic [9:0] pat   = 10'd0;
   logic [1:0] gnt;
   logic       busy;
   logic       led1, led2, led3, led4, led5;
   logic [4:0] leds;

   assign leds = {led5, led4, led3, led2, led1};

   typedef struct packed {
      logic [1:0] gnt;
      logic [4:0] leds;
   } exp_t;

   exp_t expQ[$];
   exp_t expCur;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference state, kept in terms of the observable behaviour.
   int         mTc;
   int         mHold;
   int         mLast;
   logic [1:0] mGnt;
   logic [4:0] mLeds;
   logic [4:0] mHb;

   led_bank_arbiter #(
      .NREQ(NREQ), .TICK_DIV(TDIV), .MIN_HOLD(MINH), .MAX_HOLD(MAXH)
   ) dut (
      .clki(clki), .reset(reset), .req(req), .pat(pat),
      .gnt(gnt), .busy(busy),
      .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5)
   );

   // Free-running clock.
   always #5 clki = ~clki;

   // Hard stop in case something wedges outside the bounded loops.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Puts the reference back into its post-reset state.
   task resetModel;
      mTc   = 0;
      mHold = 0;
      mLast = NREQ - 1;
      mGnt  = 2'b00;
      mLeds = 5'b00001;
      mHb   = 5'b00001;
      expQ.delete();
   endtask

   // Holds reset low for three edges with req cleared, then releases it.
   task applyReset;
      reset = 1'b0;
      req   = 2'b00;
      repeat (3) @(posedge clki);
      #1;
      reset = 1'b1;
      resetModel();
   endtask

   // Predicts the next registered outputs from the inputs currently driven,
   // queues the prediction, advances one edge and pops it into expCur.
   task applyStimulus;
      exp_t       e;
      logic       tick;
      logic       rel;
      int         w;
      logic [1:0] nGnt;
      logic [4:0] nLeds;
      logic [4:0] nHb;
      int         nHold;
      int         nLast;
      tick  = (mTc == TDIV - 1);
      nGnt  = mGnt;
      nLeds = mLeds;
      nHb   = mHb;
      nHold = mHold;
      nLast = mLast;
      if (mGnt == 2'b00) begin
         if (req != 2'b00) begin
            w = (mLast + 1) % NREQ;
            if (!req[w]) w = (w + 1) % NREQ;
            nGnt  = 2'b01 << w;
            nLast = w;
            nHold = 0;
            nLeds = pat[5*w +: 5];
         end else if (tick) begin
            nHb   = {mHb[3:0], mHb[4]};
            nLeds = nHb;
         end else begin
            nLeds = mHb;
         end
      end else begin
         rel = (!req[mLast] && mHold >= MINH) ||
               (mHold >= MAXH && (req & ~mGnt) != 2'b00);
         if (rel) begin
            nGnt  = 2'b00;
            nLeds = mHb;
         end else begin
            nLeds = pat[5*mLast +: 5];
            if (tick && mHold < MAXH) nHold = mHold + 1;
         end
      end
      e.gnt  = nGnt;
      e.leds = nLeds;
      expQ.push_back(e);
      @(posedge clki);
      #1;
      cyc++;
      mTc   = (mTc + 1) % TDIV;
      mGnt  = nGnt;
      mLeds = nLeds;
      mHb   = nHb;
      mHold = nHold;
      mLast = nLast;
      expCur = expQ.pop_front();
   endtask

   // Reset values, heartbeat cadence and asynchronous reset restoration.
   task test_reset;
      applyReset();
      checks++;
      if ({busy, gnt, leds} !== 8'b0_00_00001) begin
         failures++;
         $display("[TB] FAIL reset_state got=%b exp=%b", {busy, gnt, leds}, 8'b0_00_00001);
      end
      for (int i = 0; i < 24; i++) begin
         applyStimulus();
         checks++;
         if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
            failures++;
            $display("[TB] FAIL sb_heartbeat cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
         end
         if (i == 3) begin
            checks++;
            if (leds !== 5'b00010) begin
               failures++;
               $display("[TB] FAIL hb_first_tick got=%b exp=%b", leds, 5'b00010);
            end
         end
         if (i == 19) begin
            checks++;
            if (leds !== 5'b00001) begin
               failures++;
               $display("[TB] FAIL hb_wrap got=%b exp=%b", leds, 5'b00001);
            end
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, gnt, leds} !== 8'b0_00_00001) begin
         failures++;
         $display("[TB] FAIL hb_async_reset got=%b exp=%b", {busy, gnt, leds}, 8'b0_00_00001);
      end
      applyReset();
   endtask

   // One grant, live pattern following, then a plain release.
   task test_single_grant;
      pat = {5'b00000, 5'b10101};
      req = 2'b01;
      applyStimulus();
      checks++;
      if ({busy, gnt, leds} !== 8'b1_01_10101) begin
         failures++;
         $display("[TB] FAIL grant_latency got=%b exp=%b", {busy, gnt, leds}, 8'b1_01_10101);
      end
      pat[4:0] = 5'b01010;
      applyStimulus();
      checks++;
      if (leds !== 5'b01010) begin
         failures++;
         $display("[TB] FAIL pattern_follow got=%b exp=%b", leds, 5'b01010);
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus();
         checks++;
         if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
            failures++;
            $display("[TB] FAIL sb_single cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
         end
      end
      req = 2'b00;
      begin
         int n;
         n = 0;
         do begin
            applyStimulus();
            n++;
            checks++;
            if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
               failures++;
               $display("[TB] FAIL sb_single_rel cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
            end
         end while (gnt != 2'b00 && n < 20);
         if (gnt != 2'b00) begin
            checks++;
            failures++;
            $display("[TB] FAIL single_release got=%b exp=%b", gnt, 2'b00);
         end
      end
   endtask

   // Requester drops req right after being granted: grant held until MIN_HOLD.
   task test_min_hold;
      int held;
      req = 2'b00;
      repeat (3) applyStimulus();
      pat = {5'b00000, 5'b11011};
      req = 2'b01;
      applyStimulus();
      req = 2'b00;
      held = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         checks++;
         if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
            failures++;
            $display("[TB] FAIL sb_min_hold cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
         end
         if (gnt == 2'b01) held++;
         else break;
      end
      checks++;
      if (held < 5 || held > 8) begin
         failures++;
         $display("[TB] FAIL min_hold_len got=%0d exp=5..8", held);
      end
      checks++;
      if ($countones(leds) != 1 || gnt !== 2'b00) begin
         failures++;
         $display("[TB] FAIL min_hold_hb got=%b/%b exp=onehot/00", leds, gnt);
      end
   endtask

   // Both requesting; each owner drops after ten cycles and re-requests.
   task test_round_robin;
      logic [1:0] order[4];
      logic [1:0] expOrder[4];
      logic [1:0] prevGnt;
      int         nGrants;
      int         idleRun;
      int         grantLen;
      expOrder = '{2'b01, 2'b10, 2'b01, 2'b10};
      applyReset();
      pat      = {5'b11100, 5'b00111};
      req      = 2'b11;
      prevGnt  = 2'b00;
      nGrants  = 0;
      idleRun  = 0;
      grantLen = 0;
      for (int c = 0; c < 200 && nGrants < 4; c++) begin
         applyStimulus();
         checks++;
         if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
            failures++;
            $display("[TB] FAIL sb_rr cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
         end
         if (gnt == 2'b00) begin
            idleRun++;
            req = 2'b11;
         end else begin
            if (prevGnt == 2'b00) begin
               order[nGrants] = gnt;
               if (nGrants > 0) begin
                  checks++;
                  if (idleRun != 1) begin
                     failures++;
                     $display("[TB] FAIL rr_gap grant=%0d got=%0d exp=1", nGrants, idleRun);
                  end
               end
               nGrants++;
               grantLen = 0;
            end
            idleRun = 0;
            grantLen++;
            if (grantLen == 10) req = req & ~gnt;
         end
         prevGnt = gnt;
      end
      if (nGrants < 4) begin
         checks++;
         failures++;
         $display("[TB] FAIL rr_timeout got=%0d exp=4", nGrants);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] !== expOrder[i]) begin
               failures++;
               $display("[TB] FAIL rr_order idx=%0d got=%b exp=%b", i, order[i], expOrder[i]);
            end
         end
      end
   endtask

   // Requester 0 never lets go; requester 1 preempts it at MAX_HOLD.
   task test_max_hold;
      int held;
      int idle;
      applyReset();
      pat = {5'b10001, 5'b01110};
      req = 2'b01;
      applyStimulus();
      req  = 2'b11;
      held = 1;
      for (int i = 0; i < 40; i++) begin
         applyStimulus();
         checks++;
         if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
            failures++;
            $display("[TB] FAIL sb_max_hold cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
         end
         if (gnt == 2'b01) held++;
         else break;
      end
      checks++;
      if (held != 16 || gnt !== 2'b00) begin
         failures++;
         $display("[TB] FAIL max_hold_len got=%0d/%b exp=16/00", held, gnt);
      end
      applyStimulus();
      checks++;
      if ({gnt, leds} !== {2'b10, 5'b10001}) begin
         failures++;
         $display("[TB] FAIL preempt_grant got=%b exp=%b", {gnt, leds}, {2'b10, 5'b10001});
      end
      repeat (9) applyStimulus();
      req  = 2'b01;
      idle = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         checks++;
         if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
            failures++;
            $display("[TB] FAIL sb_regrant cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
         end
         if (gnt == 2'b00) idle++;
         if (gnt == 2'b01) break;
      end
      checks++;
      if (gnt !== 2'b01 || idle != 1) begin
         failures++;
         $display("[TB] FAIL regrant got=%b/idle%0d exp=01/idle1", gnt, idle);
      end
   endtask

   // Reset while requester 1 owns the bank, then restart with both requesting.
   task test_mid_reset;
      req = 2'b10;
      for (int i = 0; i < 30; i++) begin
         applyStimulus();
         checks++;
         if ({busy, gnt, leds} !== {|expCur.gnt, expCur.gnt, expCur.leds}) begin
            failures++;
            $display("[TB] FAIL sb_to_gnt1 cyc=%0d got=%b exp=%b", cyc, {busy, gnt, leds}, {|expCur.gnt, expCur.gnt, expCur.leds});
         end
         if (gnt == 2'b10) break;
      end
      checks++;
      if (gnt !== 2'b10) begin
         failures++;
         $display("[TB] FAIL reach_gnt1 got=%b exp=%b", gnt, 2'b10);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, gnt, leds} !== 8'b0_00_00001) begin
         failures++;
         $display("[TB] FAIL mid_reset got=%b exp=%b", {busy, gnt, leds}, 8'b0_00_00001);
      end
      req = 2'b11;
      repeat (3) @(posedge clki);
      #1;
      reset = 1'b1;
      resetModel();
      applyStimulus();
      checks++;
      if ({gnt, leds} !== {2'b01, 5'b01110}) begin
         failures++;
         $display("[TB] FAIL post_reset_first got=%b exp=%b", {gnt, leds}, {2'b01, 5'b01110});
      end
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_min_hold();
      test_round_robin();
      test_max_hold();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_bank_arbiter.md
# led_bank_arbiter

Round-robin arbiter and sequencer for the 5-LED bank on the iCE40 board top level. It shares the LEDs between NREQ requesters using a req/gnt handshake, and enforces minimum and maximum hold times measured in prescaled ticks. When no requester owns the bank, it drives a walking-one heartbeat. It sits between the chip top level (clki, reset, led1..led5) and the blocks that want to display status.

## Interface
- NREQ, 2: number of requesters (1..8).
- TICK_DIV, 1200000: clki cycles per tick (≥2); tick period = TICK_DIV cycles.
- MIN_HOLD, 4: minimum ticks a grant is held once issued (≥1).
- MAX_HOLD, 16: ticks after which a grant is revoked if another requester is waiting (>MIN_HOLD).

Ports:
- clki  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NREQ  request per requester; level, held until done.
- pat  in  5*NREQ  requested LED pattern; requester i at [5i+4:5i], bit 0 → led1.
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high while any grant is active (= |gnt).
- led1..led5  out  1 each  registered LED drives.

## Operation
- Tick prescaler: tcnt counts 0..TICK_DIV-1 and wraps. tick is 1 for the single cycle where tcnt==TICK_DIV-1. It is free-running in all states.
- Heartbeat: 3-bit hb_pos 0..4. It advances by 1 on each tick while in IDLE and wraps 4→0. It is frozen in GRANT. In IDLE, leds = one-hot(hb_pos): hb_pos 0 → led1 only.
- FSM states:
  - IDLE → GRANT when any req bit is 1. Winner = first set req index scanning last+1, last+2, … modulo NREQ. On that edge: gnt ← one-hot(winner), last ← winner, hold ← 0.
  - GRANT → IDLE when either:
    - (a) req[g]==0 and hold ≥ MIN_HOLD, or
    - (b) hold ≥ MAX_HOLD and any other req bit is 1.
  - On that edge: gnt ← 0, and leds ← heartbeat at the frozen hb_pos.
- In GRANT:
  - hold increments on each tick.
  - hold saturates at MAX_HOLD.
  - leds ← pat[5g+4:5g] every cycle, so a pattern change is visible 1 cycle later.
- A requester dropping req before MIN_HOLD keeps its grant (and keeps its last sampled pattern live) until MIN_HOLD is reached.
- hold width is clog2(MAX_HOLD+1). tcnt width is clog2(TICK_DIV). last width is clog2(NREQ), with minimum width 1.

## Timing
- Reset (async assert, sync deassert handled at top level) forces:
  - state = IDLE;
  - gnt = 0, busy = 0;
  - led1 = 1, led2..led5 = 0;
  - hb_pos = 0, tcnt = 0, hold = 0;
  - last = NREQ-1, so requester 0 wins first.
- Reset mid-grant: gnt and leds take their reset values immediately (asynchronously), with no release cycle.
- req→gnt latency:
  - req sampled high at edge N in IDLE → gnt and pattern on leds valid after edge N.
  - Both gnt and leds change on the same edge.
- Release latency: the release condition true at edge M → gnt=0 and heartbeat on leds after edge M.
- There is at least one IDLE cycle between any two grants. gnt never switches directly from one requester to another, and it is never multi-hot.
- Simultaneous requests: resolved purely by the round-robin pointer; there are no fixed priorities.
- tick coincident with a release edge: hold may increment on the same edge but is irrelevant once in IDLE. hb_pos does not advance on the release edge; it advances from the next tick.
- tick coincident with a grant edge: hold ← 0 (the grant wins over the increment). hb_pos does not advance.
- When (a) and (b) are both true, the result is the same: release.

## Test plan
Bench parameters: NREQ=2, TICK_DIV=4, MIN_HOLD=2, MAX_HOLD=4.

- **Reset/heartbeat:** reset=0 for 3 cycles, then 1, with req=0.
  - Expect leds 00001 and gnt=00.
  - leds advance 00010, 00100, 01000, 10000, 00001 once every 4 cycles.
  - Asserting reset at any point restores 00001 immediately.
- **Single grant:** req=01, pat0=10101.
  - Expect gnt=01, busy=1, leds=10101 after 1 edge.
  - Change pat0 to 01010 → leds follow 1 cycle later.
- **Min hold:** requester 0 drops req 1 cycle after its grant.
  - Expect gnt held until hold=2 (about 8 cycles), then gnt=00.
  - leds return to the frozen heartbeat pattern on the same edge.
- **Round-robin:** req=11 held continuously, with requesters dropping req after MIN_HOLD.
  - Expect grant order 01, 10, 01, 10.
  - Exactly one gnt=00 cycle between consecutive grants.
- **Max-hold preemption:** requester 0 holds req high, requester 1 raises req.
  - Expect gnt0 revoked at hold=4 ticks.
  - One idle cycle, then gnt=10.
  - Afterwards, requester 0 is re-granted after requester 1 releases.
- **Mid-grant reset:** assert reset while gnt=10.
  - Expect gnt=00 and leds=00001 immediately.
  - After deassert with req=11, the first grant goes to requester 0.
